// File: rtl/xor_lane_pkg.sv
// ---------------------------------------------------------------------------------------------
// xor_lane_pkg
//  Shared definitions for the xor_lane_pipe block: operation mode encodings, the accumulate
//  FSM state type and a small mode-decode helper.
//  No ports (package).
// ---------------------------------------------------------------------------------------------
package xor_lane_pkg;

    localparam logic [1:0] MODE_XOR   = 2'b00;
    localparam logic [1:0] MODE_XNOR  = 2'b01;
    localparam logic [1:0] MODE_ACCUM = 2'b10;
    // 2'b11 is reserved and behaves as MODE_XOR.

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    // Only XNOR inverts; the reserved code falls through to plain XOR.
    function automatic logic mode_inverts(input logic [1:0] mode);
        return (mode == MODE_XNOR);
    endfunction

endpackage

// File: rtl/xor_lane_fold.sv
// ---------------------------------------------------------------------------------------------
// xor_lane_fold
//  Combinational WIDTH-bit fold: y = seed ^ a ^ b, optionally inverted. The same datapath
//  serves single-beat XOR/XNOR (seed = 0) and burst accumulation (seed = running checksum).
//  Ports:
//   seed    in  WIDTH  running accumulator value (0 outside a burst)
//   a       in  WIDTH  operand A
//   b       in  WIDTH  operand B
//   invert  in  1      invert the folded result (XNOR)
//   y       out WIDTH  folded result
// ---------------------------------------------------------------------------------------------
module xor_lane_fold #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             invert,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] raw;

    always_comb begin
        raw = seed ^ a ^ b;
        y   = invert ? ~raw : raw;
    end

endmodule

// File: rtl/xor_lane_pipe.sv
// ---------------------------------------------------------------------------------------------
// xor_lane_pipe
//  Registered WIDTH-bit XOR lane with valid/ready handshake. Each accepted beat produces one
//  result (XOR or XNOR of A and B) one cycle later, or, in ACCUM mode, a burst of beats is
//  folded into a single running-checksum result emitted one cycle after the IN_LAST beat.
//  One output register stage; back-to-back throughput of one result per clock.
//
//  Optional feature: define XOR_PARITY_EN to add OUT_PAR (reduction XOR of Y, registered with Y).
//
//  Ports:
//   CLK        in   1      clock, rising edge
//   RST        in   1      synchronous reset, active high
//   MODE       in   2      00 XOR, 01 XNOR, 10 ACCUM, 11 reserved (XOR)
//   A, B       in   WIDTH  operands
//   IN_VALID   in   1      A/B/MODE/IN_LAST valid
//   IN_LAST    in   1      last beat of an ACCUM burst
//   IN_READY   out  1      beat accepted when IN_VALID & IN_READY
//   Y          out  WIDTH  result
//   OUT_VALID  out  1      Y/OUT_CNT valid
//   OUT_READY  in   1      consumer takes result when OUT_VALID & OUT_READY
//   OUT_CNT    out  CNT_W  beats folded into Y (saturating)
//   OUT_PAR    out  1      XOR_PARITY_EN only: ^Y
// ---------------------------------------------------------------------------------------------
module xor_lane_pipe
    import xor_lane_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             IN_VALID,
    input  logic             IN_LAST,
    output logic             IN_READY,
    output logic [WIDTH-1:0] Y,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [CNT_W-1:0] OUT_CNT
`ifdef XOR_PARITY_EN
    ,
    output logic             OUT_PAR
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] y_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] out_cnt_q;
`ifdef XOR_PARITY_EN
    logic             out_par_q;
`endif

    logic             in_ready;
    logic             accept;
    logic             in_burst;
    logic [WIDTH-1:0] fold_seed;
    logic             fold_invert;
    logic [WIDTH-1:0] fold_y;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        // Output slot is free if empty or being drained this cycle.
        in_ready    = !RST && (!out_valid_q || OUT_READY);
        accept      = IN_VALID && in_ready;
        in_burst    = (state_q == BURST);
        // Inside a burst the mode was latched at the first beat, so MODE is ignored here.
        fold_seed   = in_burst ? acc_q : '0;
        fold_invert = !in_burst && mode_inverts(MODE);
        cnt_inc     = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
    end

    xor_lane_fold #(
        .WIDTH (WIDTH)
    ) u_fold (
        .seed   (fold_seed),
        .a      (A),
        .b      (B),
        .invert (fold_invert),
        .y      (fold_y)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            out_cnt_q   <= '0;
`ifdef XOR_PARITY_EN
            out_par_q   <= 1'b0;
`endif
        end else begin
            // Drain on handshake; a result loaded below in the same cycle overrides this.
            if (out_valid_q && OUT_READY) begin
                out_valid_q <= 1'b0;
            end

            if (accept) begin
                unique case (state_q)
                    IDLE: begin
                        if ((MODE == MODE_ACCUM) && !IN_LAST) begin
                            acc_q   <= fold_y;
                            cnt_q   <= CNT_ONE;
                            state_q <= BURST;
                        end else begin
                            // Per-beat XOR/XNOR, or a one-beat ACCUM burst.
                            y_q         <= fold_y;
                            out_cnt_q   <= CNT_ONE;
                            out_valid_q <= 1'b1;
`ifdef XOR_PARITY_EN
                            out_par_q   <= ^fold_y;
`endif
                        end
                    end
                    BURST: begin
                        if (IN_LAST) begin
                            y_q         <= fold_y;
                            out_cnt_q   <= cnt_inc;
                            out_valid_q <= 1'b1;
`ifdef XOR_PARITY_EN
                            out_par_q   <= ^fold_y;
`endif
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            state_q     <= IDLE;
                        end else begin
                            acc_q <= fold_y;
                            cnt_q <= cnt_inc;
                        end
                    end
                endcase
            end
        end
    end

    assign IN_READY  = in_ready;
    assign Y         = y_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_CNT   = out_cnt_q;
`ifdef XOR_PARITY_EN
    assign OUT_PAR   = out_par_q;
`endif

endmodule

// File: tb/tb_xor_lane_pipe.sv
// ---------------------------------------------------------------------------------------------
// tb_xor_lane_pipe
//  Two instances share one stimulus: the default build (CNT_W=8) and a CNT_W=2 build used to
//  exercise counter saturation. A transaction-level reference (queue of pending results plus
//  the list of beats in the open burst) predicts every output. Define XOR_PARITY_EN to also
//  cover OUT_PAR.
// ---------------------------------------------------------------------------------------------
module tb_xor_lane_pipe;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic [3:0] a;
    logic [3:0] b;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;

    logic       in_ready;
    logic [3:0] y;
    logic       out_valid;
    logic [7:0] out_cnt;
    logic       in_ready2;
    logic [3:0] y2;
    logic       out_valid2;
    logic [1:0] out_cnt2;
`ifdef XOR_PARITY_EN
    logic       out_par;
    logic       out_par2;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] y;
        int         n;
    } res_t;

    res_t       exp_q[$];
    logic [3:0] beats[$];
    bit         stalled = 1'b0;

    xor_lane_pipe #(
        .WIDTH (4),
        .CNT_W (8)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .MODE      (mode),
        .A         (a),
        .B         (b),
        .IN_VALID  (in_valid),
        .IN_LAST   (in_last),
        .IN_READY  (in_ready),
        .Y         (y),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_CNT   (out_cnt)
`ifdef XOR_PARITY_EN
        ,
        .OUT_PAR   (out_par)
`endif
    );

    xor_lane_pipe #(
        .WIDTH (4),
        .CNT_W (2)
    ) dut2 (
        .CLK       (clk),
        .RST       (rst),
        .MODE      (mode),
        .A         (a),
        .B         (b),
        .IN_VALID  (in_valid),
        .IN_LAST   (in_last),
        .IN_READY  (in_ready2),
        .Y         (y2),
        .OUT_VALID (out_valid2),
        .OUT_READY (out_ready),
        .OUT_CNT   (out_cnt2)
`ifdef XOR_PARITY_EN
        ,
        .OUT_PAR   (out_par2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int n, input int max);
        return (n > max) ? max : n;
    endfunction

    // Compare current outputs against the head of the expected queue.
    task automatic check_outputs();
        check("out_valid", out_valid, exp_q.size() != 0);
        check("out_valid2", out_valid2, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("y", y, exp_q[0].y);
            check("out_cnt", out_cnt, sat(exp_q[0].n, 255));
            check("y2", y2, exp_q[0].y);
            check("out_cnt2", out_cnt2, sat(exp_q[0].n, 3));
`ifdef XOR_PARITY_EN
            check("out_par", out_par, ^exp_q[0].y);
            check("out_par2", out_par2, ^exp_q[0].y);
`endif
        end
    endtask

    // Predict the handshake for the coming edge and advance the reference.
    task automatic model_step();
        bit         ready;
        bit         take;
        logic [3:0] f;
        ready = !rst && (exp_q.size() == 0 || out_ready);
        check("in_ready", in_ready, ready);
        check("in_ready2", in_ready2, ready);
        if (rst) begin
            exp_q.delete();
            beats.delete();
            stalled = 1'b0;
            return;
        end
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        take    = in_valid && ready;
        stalled = in_valid && !ready;
        if (take) begin
            if (beats.size() == 0 && mode != 2'b10) begin
                f = (mode == 2'b01) ? ~(a ^ b) : (a ^ b);
                exp_q.push_back('{y: f, n: 1});
            end else begin
                beats.push_back(a ^ b);
                if (in_last) begin
                    f = 4'h0;
                    foreach (beats[i]) f ^= beats[i];
                    exp_q.push_back('{y: f, n: beats.size()});
                    beats.delete();
                end
            end
        end
    endtask

    // One clock: check at the falling edge, then return 1 time unit after the rising edge.
    task automatic step();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] m, input logic [3:0] va, input logic [3:0] vb,
                        input logic last);
        mode     = m;
        a        = va;
        b        = vb;
        in_last  = last;
        in_valid = 1'b1;
        step();
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] ey,
                           input logic [7:0] ec);
        check(tag, {out_valid, y, out_cnt}, {v, ey, ec});
    endtask

    initial begin
        rst = 1'b1; mode = 2'b00; a = 4'h0; b = 4'h0;
        in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b1;

        // Reset held two clocks with IN_VALID high.
        step();
        step();
        chk_out("reset_state", 1'b0, 4'h0, 8'h00);
        check("reset_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("release_in_ready", in_ready, 1'b1);
        step();

        // XOR stream, back-to-back.
        beat(2'b00, 4'hA, 4'h5, 1'b0);
        chk_out("xor_first", 1'b1, 4'hF, 8'h01);
        beat(2'b00, 4'hF, 4'h3, 1'b0);
        chk_out("xor_second", 1'b1, 4'hC, 8'h01);
        in_valid = 1'b0;
        step();
        chk_out("xor_drained", 1'b0, 4'hC, 8'h01);

        // XNOR with backpressure.
        out_ready = 1'b0;
        beat(2'b01, 4'h6, 4'h3, 1'b0);
        chk_out("xnor_load", 1'b1, 4'hA, 8'h01);
        a = 4'h1; b = 4'h1;
        repeat (3) step();
        chk_out("xnor_hold", 1'b1, 4'hA, 8'h01);
        check("xnor_stall_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        step();
        chk_out("xnor_next", 1'b1, 4'hF, 8'h01);
        in_valid = 1'b0;
        step();

        // ACCUM burst with MODE changed mid-burst.
        beat(2'b10, 4'h1, 4'h2, 1'b0);
        chk_out("accum_no_out1", 1'b0, 4'hF, 8'h01);
        beat(2'b00, 4'h4, 4'h8, 1'b0);
        chk_out("accum_no_out2", 1'b0, 4'hF, 8'h01);
        beat(2'b00, 4'hF, 4'h0, 1'b1);
        chk_out("accum_result", 1'b1, 4'h0, 8'h03);
        in_valid = 1'b0;
        step();

        // ACCUM single-beat burst, then reset in the middle of a burst.
        beat(2'b10, 4'h9, 4'h1, 1'b1);
        chk_out("accum_single", 1'b1, 4'h8, 8'h01);
        for (int i = 0; i < 3; i++) beat(2'b10, 4'h5, 4'h0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_out("midburst_reset", 1'b0, 4'h0, 8'h00);
        beat(2'b10, 4'h2, 4'h0, 1'b0);
        beat(2'b10, 4'h0, 4'h1, 1'b1);
        chk_out("after_reset_burst", 1'b1, 4'h3, 8'h02);
        in_valid = 1'b0;
        step();

        // Six-beat burst: saturates the 2-bit counter only.
        for (int i = 0; i < 5; i++) beat(2'b10, 4'h1, 4'h0, 1'b0);
        beat(2'b10, 4'h1, 4'h0, 1'b1);
        chk_out("sat_wide", 1'b1, 4'h0, 8'h06);
        check("sat_narrow_cnt", out_cnt2, 2'd3);
        beat(2'b00, 4'h7, 4'h0, 1'b0);
        chk_out("y7", 1'b1, 4'h7, 8'h01);
`ifdef XOR_PARITY_EN
        check("par_y7", out_par, 1'b1);
`endif
        in_valid = 1'b0;
        step();

        // Randomised traffic; operands are held while a beat is stalled.
        for (int i = 0; i < 400; i++) begin
            if (!stalled) begin
                mode     = 2'($urandom_range(0, 3));
                a        = 4'($urandom_range(0, 15));
                b        = 4'($urandom_range(0, 15));
                in_last  = ($urandom_range(0, 3) == 0);
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            rst       = ($urandom_range(0, 79) == 0);
            step();
        end

        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
